// File: rtl/line_cropper_if.sv
// Video stream bundle for line_cropper: DVP-style input side (sync, valid,
// RGB888 data, crop enable) and the registered, cropped output side.
interface line_cropper_if;
  logic        EN;
  logic        pre_vs;
  logic        pre_de;
  logic [23:0] pre_data;
  logic        post_vs;
  logic        post_de;
  logic [23:0] post_data;
  logic [11:0] frame_lines;

  modport master (
    output EN, pre_vs, pre_de, pre_data,
    input  post_vs, post_de, post_data, frame_lines
  );

  modport slave (
    input  EN, pre_vs, pre_de, pre_data,
    output post_vs, post_de, post_data, frame_lines
  );
endinterface

// File: rtl/line_cropper.sv
// line_cropper: trims each incoming line to H_DISP pixels starting at pixel
// H_OFFSET. It never pads; short lines come out short. Output is registered
// with one cycle of latency, and post_vs/post_de/post_data stay aligned.
// Optional vertical window: define LINE_CROPPER_VCROP_EN to keep only lines
// V_OFFSET .. V_OFFSET+V_DISP-1 after pre_vs. Without it, every line is kept.
//
// state  | meaning
// S_IDLE | between lines, or pre_vs high; waiting for the first pixel
// S_SKIP | leading pixels (pix_x < H_OFFSET), discarded
// S_PASS | window pixels, forwarded in crop mode
// S_DROP | trailing pixels after the window, discarded
module line_cropper #(
  parameter logic [11:0] H_DISP   = 12'd1280,
  parameter logic [11:0] H_OFFSET = 12'd0,
  parameter logic [11:0] V_DISP   = 12'd720,
  parameter logic [11:0] V_OFFSET = 12'd0
) (
  input  logic          pre_clk,
  input  logic          rst,
  output logic          post_clk,
  line_cropper_if.slave vid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_PASS = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [11:0] CNT_MAX = 12'hfff;

  state_t      state_q;
  state_t      state_nxt;
  logic [11:0] pix_x;
  logic [11:0] line_y;
  logic [11:0] pass_left;
  logic [11:0] frame_lines_q;
  logic        armed_q;
  logic        de_q;
  logic        en_q;
  logic        vs_q;
  logic        post_de_q;
  logic [23:0] post_data_q;
  logic        start_line;
  logic        en_eff;
  logic        line_ok;
  logic        in_vwin;
  logic        de_nxt;
  logic [23:0] data_nxt;

  assign post_clk = pre_clk;

  // 13-bit compare so V_OFFSET + V_DISP cannot wrap.
  assign in_vwin = ({1'b0, line_y} >= {1'b0, V_OFFSET}) &&
                   ({1'b0, line_y} < ({1'b0, V_OFFSET} + {1'b0, V_DISP}));

`ifdef LINE_CROPPER_VCROP_EN
  assign line_ok = in_vwin;
`else
  logic unused_vwin;
  assign unused_vwin = in_vwin;
  assign line_ok     = 1'b1;
`endif

  // State register.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Region of the current pixel, plus next-cycle output values. The region is
  // decided for the pixel on the bus this cycle, so with H_OFFSET = 0 the
  // first pixel of a line already lands in S_PASS.
  always_comb begin
    state_nxt  = state_q;
    start_line = 1'b0;
    de_nxt     = 1'b0;
    data_nxt   = 24'h000000;

    if (vid.pre_vs || !vid.pre_de) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // armed_q blocks a line that was already running when reset released.
          if (armed_q) begin
            start_line = 1'b1;
            state_nxt  = (H_OFFSET != 12'd0) ? S_SKIP : S_PASS;
          end
        end
        S_SKIP: begin
          if (pix_x == H_OFFSET) begin
            state_nxt = S_PASS;
          end
        end
        S_PASS: begin
          if (pass_left == 12'd0) begin
            state_nxt = S_DROP;
          end
        end
        S_DROP: begin
          state_nxt = S_DROP;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    // EN only counts at the first pixel of a line; otherwise use the latched copy.
    en_eff = start_line ? vid.EN : en_q;

    if (en_eff) begin
      de_nxt = (state_nxt == S_PASS) && line_ok;
      if (de_nxt) begin
        data_nxt = vid.pre_data;
      end
    end else begin
      de_nxt   = vid.pre_de && armed_q;
      data_nxt = vid.pre_data;
    end
  end

  // Pixel index, window down-counter, line-start qualifiers and latched EN.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      pix_x     <= 12'd0;
      pass_left <= 12'd0;
      armed_q   <= 1'b0;
      de_q      <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      if (vid.pre_vs || !vid.pre_de) begin
        pix_x <= 12'd0;
      end else if (pix_x != CNT_MAX) begin
        pix_x <= pix_x + 12'd1;
      end

      // Loaded on entry to S_PASS; terminal count 0 marks the last window pixel.
      if (state_nxt == S_PASS) begin
        pass_left <= (state_q == S_PASS) ? (pass_left - 12'd1) : (H_DISP - 12'd1);
      end

      if (!vid.pre_de) begin
        armed_q <= 1'b1;
      end

      if (start_line) begin
        en_q <= vid.EN;
      end

      de_q <= vid.pre_de;
    end
  end

  // Line counter since pre_vs, saturating, and per-frame line count capture.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      line_y        <= 12'd0;
      frame_lines_q <= 12'd0;
    end else begin
      if (vid.pre_vs) begin
        line_y <= 12'd0;
      end else if (armed_q && de_q && !vid.pre_de && (line_y != CNT_MAX)) begin
        line_y <= line_y + 12'd1;
      end

      if (vid.pre_vs && !vs_q) begin
        frame_lines_q <= line_y;
      end
    end
  end

  // Output register: one cycle of latency on every output.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b0;
      post_de_q   <= 1'b0;
      post_data_q <= 24'h000000;
    end else begin
      vs_q        <= vid.pre_vs;
      post_de_q   <= de_nxt;
      post_data_q <= data_nxt;
    end
  end

  assign vid.post_vs     = vs_q;
  assign vid.post_de     = post_de_q;
  assign vid.post_data   = post_data_q;
  assign vid.frame_lines = frame_lines_q;

endmodule

// File: doc/line_cropper.md
# line_cropper

Windowing block for the DVP video path: trims each incoming line to `H_DISP` pixels starting at pixel `H_OFFSET`, and optionally keeps only `V_DISP` lines starting at line `V_OFFSET`. It sits upstream of the black-padding filler, reducing an oversized sensor raster to the display geometry. It never pads: short lines are passed short, and downstream logic squares them up. Output is registered, with one cycle of latency and all sync signals aligned.

## Interface
- `H_DISP`, 12'd1280, output pixels per line (1..4095)
- `H_OFFSET`, 12'd0, input pixels discarded at the start of each line (H_OFFSET + H_DISP ≤ 4095)
- `V_DISP`, 12'd720, output lines per frame (used only with `LINE_CROPPER_VCROP_EN`)
- `V_OFFSET`, 12'd0, input lines discarded after `pre_vs` (used only with `LINE_CROPPER_VCROP_EN`)
- `pre_clk  in  1  pixel clock; the single clock; post_clk = pre_clk`
- `rst  in  1  asynchronous, active-high reset`
- `EN  in  1  1 = crop, 0 = registered bypass`
- `pre_vs  in  1  frame sync, active high`
- `pre_de  in  1  pixel valid`
- `pre_data  in  24  RGB888 pixel`
- `post_clk  out  1  equal to pre_clk`
- `post_vs  out  1  pre_vs delayed 1 cycle`
- `post_de  out  1  cropped pixel valid`
- `post_data  out  24  cropped pixel; 24'h000000 whenever post_de = 0 in crop mode`
- `frame_lines  out  12  pre_de lines counted in the previous frame`

## Operation
- Counters:
  - `pix_x` (12 b) is the index of the current pre_de pixel within its line.
  - `line_y` (12 b) counts completed lines since the last `pre_vs`.
  - A line completes on each pre_de falling edge (previous cycle high, current cycle low).
  - `line_y` saturates at 4095 and never wraps.
- State machine, one region per line:
  - IDLE: between lines. The first pre_de pixel goes to SKIP if H_OFFSET > 0, otherwise to PASS.
  - SKIP: pixels with pix_x < H_OFFSET. Goes to PASS when pix_x reaches H_OFFSET.
  - PASS: pixels with H_OFFSET ≤ pix_x < H_OFFSET + H_DISP. Goes to DROP after pixel H_OFFSET + H_DISP − 1.
  - DROP: remaining pixels of the line.
  - pre_de low in any state returns to IDLE, and pix_x resets to 0.
- Each state is evaluated for the current pixel, so with H_OFFSET = 0 the first pixel of a line is passed.
- In crop mode, post_de = 1 only for PASS-region pixels of an accepted line. post_data then equals pre_data; otherwise it is 0.
- Line acceptance:
  - With `LINE_CROPPER_VCROP_EN`: accepted iff V_OFFSET ≤ line_y < V_OFFSET + V_DISP.
  - Without it: every line is accepted.
- EN is sampled only at the first pixel of a line (IDLE → non-IDLE), so a mid-line toggle takes effect from the next line. In bypass, post_de = pre_de and post_data = pre_data, both 1 cycle late.
- pre_vs high:
  - forces IDLE;
  - clears pix_x and line_y;
  - holds post_de = 0 in crop mode;
  - on the rising edge, latches line_y into frame_lines.
- Short line (pre_de falls inside SKIP or PASS): output is truncated, nothing is padded, and line_y still increments.
- Simultaneous pre_vs and pre_de: pre_vs wins and the pixel is dropped in crop mode.

## Timing
- Latency is 1 pre_clk for post_vs, post_de and post_data, in both modes.
- Reset values: post_vs = 0, post_de = 0, post_data = 0, frame_lines = 0, state = IDLE, pix_x = 0, line_y = 0, latched EN = 0.
- Reset asserted mid-line clears everything immediately, and post_de drops asynchronously. After release, the block waits for the next pre_de low → high transition. It does not resume the partial line.
- post_de in crop mode is contiguous within a line: exactly min(H_DISP, max(0, line_len − H_OFFSET)) cycles.

## Configuration
- Macro: `LINE_CROPPER_VCROP_EN`.
- Defined: the vertical window (V_OFFSET, V_DISP) is applied, and lines outside it output post_de = 0.
- Undefined: V_OFFSET and V_DISP are ignored and all lines are accepted. line_y and frame_lines still operate.

## Test plan
All cases use H_DISP = 4 and H_OFFSET = 2 unless stated.
- 8-pixel line with data 1..8, EN = 1 → post_de high for 4 cycles carrying 3, 4, 5, 6, starting 3 cycles after the first pre_de; post_data is 0 elsewhere.
- 4-pixel short line with data 1..4 → 2 output pixels (3, 4) and no padding; next 8-pixel line crops normally.
- EN = 0, 8-pixel line → all 8 pixels out, 1-cycle delayed; EN raised mid-line → that line is still bypassed, the next line is cropped.
- VCROP_EN, V_OFFSET = 1, V_DISP = 2, 5 lines of 8 pixels → lines 1 and 2 output 4 pixels each; lines 0, 3, 4 output none. Next pre_vs rise → frame_lines = 5.
- rst pulsed during PASS of line 0 → post_de = 0 immediately, all outputs 0; after release, a new line starting at the next pre_de rise crops correctly.
- H_OFFSET = 0, 6-pixel line → first 4 pixels pass, including the first one.
